// File: rtl/simon_pkg.sv
// Shared types for the Simon round checker: result codes, FSM states and a
// symbol-width helper that never returns zero.
package simon_pkg;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_WRONG   = 2'd1,
    FAIL_TIMEOUT = 2'd2,
    FAIL_EMPTY   = 2'd3
  } fail_code_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    FINISH
  } state_e;

  function automatic int sym_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Turns a button vector into a symbol index; valid only when exactly one
// button is pressed.
module onehot_encoder
  import simon_pkg::*;
#(
  parameter int NUM_BUTTONS = 4,
  localparam int SYM_W = sym_w(NUM_BUTTONS)
) (
  input  logic [NUM_BUTTONS-1:0] onehot,
  output logic [SYM_W-1:0]       symbol,
  output logic                   valid
);

  always_comb begin
    symbol = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (onehot[i]) symbol = SYM_W'(i);
    end
    valid = (onehot != '0) && ((onehot & (onehot - NUM_BUTTONS'(1))) == '0);
  end

endmodule

// File: rtl/sequence_checker.sv
// Checks one round of player presses against the stored colour sequence,
// reporting every accepted press and a final pass/fail with cause.
module sequence_checker
  import simon_pkg::*;
#(
  parameter int NUM_BUTTONS    = 4,
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int SYM_W = sym_w(NUM_BUTTONS),
  localparam int IDX_W = $clog2(MAX_LEN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MAX_LEN-1:0][SYM_W:0]  segment,
  input  logic [IDX_W:0]               round_len,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_BUTTONS-1:0]       player_input,
  output logic                         busy,
  output logic [IDX_W-1:0]             check_idx,
  output logic                         step_valid,
  output logic                         step_ok,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(MAX_LEN);

  state_e                 state;
  logic [NUM_BUTTONS-1:0] prev_input;
  logic [TMR_W-1:0]       timer;
  logic [IDX_W:0]         len_q;
  logic [SYM_W-1:0]       press_sym;
  logic                   press_onehot;
  logic                   press_event;
  logic                   cur_empty;
  logic [SYM_W-1:0]       cur_sym;
  logic                   last_step;
  logic                   timeout_hit;

  onehot_encoder #(.NUM_BUTTONS(NUM_BUTTONS)) u_enc (
    .onehot (player_input),
    .symbol (press_sym),
    .valid  (press_onehot)
  );

  // A press only counts on a rising edge from all-released, so a button held
  // into WAIT_PRESS must be released before it can score.
  assign press_event = (prev_input == '0) && (player_input != '0);
  assign cur_empty   = segment[check_idx][SYM_W];
  assign cur_sym     = segment[check_idx][SYM_W-1:0];
  assign last_step   = ({1'b0, check_idx} == len_q - (IDX_W + 1)'(1));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMR_LAST);

  // Protocol: start is sampled only in IDLE; done pulses once per round and
  // pass/fail_code stay valid until the next accepted start. abort wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_input <= '0;
      timer      <= '0;
      len_q      <= '0;
      busy       <= 1'b0;
      check_idx  <= '0;
      step_valid <= 1'b0;
      step_ok    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_code  <= FAIL_NONE;
    end else begin
      prev_input <= player_input;
      step_valid <= 1'b0;
      step_ok    <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_q     <= (round_len > LEN_MAX) ? LEN_MAX : round_len;
              check_idx <= '0;
              pass      <= 1'b0;
              fail_code <= FAIL_NONE;
              timer     <= '0;
              busy      <= 1'b1;
              if (round_len == '0) begin
                state <= FINISH;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                state <= WAIT_PRESS;
              end
            end
          end
          WAIT_PRESS: begin
            if (cur_empty) begin
              state     <= FINISH;
              done      <= 1'b1;
              fail_code <= FAIL_EMPTY;
            end else if (press_event) begin
              step_valid <= 1'b1;
              if (press_onehot && (press_sym == cur_sym)) begin
                step_ok <= 1'b1;
                if (last_step) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  pass  <= 1'b1;
                end else begin
                  check_idx <= check_idx + IDX_W'(1);
                  state     <= WAIT_RELEASE;
                end
              end else begin
                state     <= FINISH;
                done      <= 1'b1;
                fail_code <= FAIL_WRONG;
              end
            end else begin
              if (timer != '1) timer <= timer + TMR_W'(1);
              if (timeout_hit) begin
                state     <= FINISH;
                done      <= 1'b1;
                fail_code <= FAIL_TIMEOUT;
              end
            end
          end
          WAIT_RELEASE: begin
            if (player_input == '0) begin
              timer <= '0;
              state <= WAIT_PRESS;
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
